// File: rtl/moxie_bus_pkg.sv
// Shared Wishbone bus definitions for the moxie core bus fabric.
package moxie_bus_pkg;

    localparam int unsigned WB_DAT_W = 16;
    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_SEL_W = WB_DAT_W / 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts unacknowledged strobe cycles of the
// current owner and pulses err_o for one cycle when the limit is reached.
module wb_arb_watchdog #(
    parameter int unsigned TimeoutCycles = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic ack_i,
    input  logic clear_i,
    output logic err_o
);

    localparam logic [7:0] Limit = 8'(TimeoutCycles);

    logic [7:0] cnt_q, cnt_d;

    assign err_o = (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (err_o || ack_i || clear_i) begin
            cnt_d = '0;
        end else if (busy_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter2_ram16.sv
// Round-robin two-master Wishbone arbiter in front of a 16-bit RAM slave.
// Optional stall watchdog built when ARB_WATCHDOG_EN is defined.
module wb_arbiter2_ram16
    import moxie_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic                m0_we_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic                m1_we_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i
);

    arb_state_t state_q, state_d;
    arb_state_t stb_own_q;
    logic       last_q, last_d;
    logic       ack0, ack1;
    logic       wd_err;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (m0_cyc_i) begin
                    state_d = StOwn0;
                end else if (m1_cyc_i) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? StOwn1 : StIdle;
                end
            end
            StOwn1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? StOwn0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            stb_own_q <= StIdle;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            // Which owner issued the strobe the slave is answering next cycle.
            stb_own_q <= s_stb_o ? state_q : StIdle;
        end
    end

    // An ack is only genuine if the same owner strobed in the previous cycle.
    assign ack0 = s_ack_i && (state_q == StOwn0) && (stb_own_q == StOwn0);
    assign ack1 = s_ack_i && (state_q == StOwn1) && (stb_own_q == StOwn1);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            StOwn0: begin
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_cyc_i && m0_stb_i && !wd_err;
                m0_ack_o = ack0;
                m0_err_o = wd_err;
            end
            StOwn1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_cyc_i && m1_stb_i && !wd_err;
                m1_ack_o = ack1;
                m1_err_o = wd_err;
            end
            default: ;
        endcase
    end

`ifdef ARB_WATCHDOG_EN
    logic wd_busy;

    assign wd_busy = ((state_q == StOwn0) && m0_cyc_i && m0_stb_i) ||
                     ((state_q == StOwn1) && m1_cyc_i && m1_stb_i);

    wb_arb_watchdog #(
        .TimeoutCycles(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .busy_i (wd_busy),
        .ack_i  (ack0 || ack1),
        .clear_i(state_d != state_q),
        .err_o  (wd_err)
    );
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign wd_err         = 1'b0;
`endif

endmodule

// File: doc/wb_arbiter2_ram16.md
# wb_arbiter2_ram16

Two-master Wishbone arbiter that shares a single 16-bit Wishbone RAM slave (4K x 16, single-cycle registered ack) between an instruction-fetch master (m0) and a data master (m1). It sits between the moxie core's bus ports and the RAM. It grants ownership round-robin, holds the grant for the owner's whole `cyc` burst, and routes strobes and acks. An optional watchdog terminates stalled cycles with `err`.

## Interface
- `TIMEOUT_CYCLES`, 15: number of consecutive unacknowledged strobe cycles before watchdog `err`. Range 2..255.
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `m0_adr_i`, `m1_adr_i` in 32: master addresses.
- `m0_dat_i`, `m1_dat_i` in 16: master write data.
- `m0_sel_i`, `m1_sel_i` in 2: byte selects.
- `m0_we_i`, `m1_we_i`, `m0_cyc_i`, `m1_cyc_i`, `m0_stb_i`, `m1_stb_i` in 1: master controls.
- `m0_dat_o`, `m1_dat_o` out 16: read data, both driven from `s_dat_i`.
- `m0_ack_o`, `m1_ack_o` out 1: acks, gated to owner.
- `m0_err_o`, `m1_err_o` out 1: watchdog error, gated to owner.
- `s_adr_o` out 32, `s_dat_o` out 16, `s_sel_o` out 2, `s_we_o`/`s_cyc_o`/`s_stb_o` out 1: muxed slave request.
- `s_dat_i` in 16, `s_ack_i` in 1: slave response.

## Operation
- States: IDLE, OWN0, OWN1. Register `last` records the last-granted master.
- IDLE:
  - only `mX_cyc_i` high -> OWNX.
  - both high -> grant the master not equal to `last`.
  - neither -> stay IDLE.
- OWNX:
  - Slave bus = master X fields. `s_cyc_o = mX_cyc_i`, `s_stb_o = mX_cyc_i & mX_stb_i`.
  - `mX_ack_o = s_ack_i`. Non-owner ack/err forced 0.
- On leaving OWNX, set `last = X`. Transition happens when `mX_cyc_i` is sampled low:
  - other master's `cyc` high -> go directly to OWN(other), no IDLE bubble.
  - otherwise -> IDLE.
- In IDLE all `s_*` controls are 0. `s_adr_o`/`s_dat_o`/`s_sel_o` follow m0 (don't-care).
- A master's `cyc` is never preempted. A locked burst of any length holds the grant.
- `s_ack_i` arriving in IDLE, or after ownership changed, is discarded (not forwarded).

## Timing
- Request sampled in IDLE at edge N -> OWN state from N+1. `s_stb_o` high during cycle N+1. Slave ack during N+2, forwarded combinationally to the owner.
- Back-to-back strobes within an owned burst: one transfer per 2 cycles. Stb is deasserted by the master on ack, following the slave's registered ack.
- Handover: owner `cyc` low at edge N -> other master owns from N+1.
- Reset: `rst_i` low at an edge -> next cycle state IDLE and `last = 1` (m0 wins first tie). All acks, errs, `s_cyc_o` and `s_stb_o` are 0. Applies mid-burst as well; an in-flight slave ack is dropped.
- Simultaneous requests from IDLE with `last = 0` -> m1 granted, then m0, alternating.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - An 8-bit counter increments each cycle the owner has `stb & cyc` high and `s_ack_i` is low. It clears on ack, on ownership change, and on reset.
  - When the count reaches `TIMEOUT_CYCLES`, `mX_err_o` pulses for exactly 1 cycle, `s_stb_o` is forced low that cycle, and the counter clears.
  - Ownership is unchanged; the master decides whether to drop `cyc`.
- `ARB_WATCHDOG_EN` undefined: no counter is built and `m0_err_o`/`m1_err_o` are tied 0.

## Structure
- Shared package (`moxie_bus_pkg`):
  - state encoding typedef `arb_state_t` {IDLE, OWN0, OWN1}.
  - `WB_DAT_W = 16`, `WB_ADR_W = 32`.
- One natural sub-module: `wb_arb_watchdog` (counter plus err pulse), instantiated only under `ARB_WATCHDOG_EN`. Everything else is flat.

## Test plan
- Single master: m0 reads adr 0x0000_0010 after a write of 0xBEEF -> m0 ack 2 cycles after request, `m0_dat_o = 0xBEEF`. m1 ack/err stay 0.
- Simultaneous request after reset -> m0 granted first. On m0 `cyc` drop, m1 is granted next cycle with no IDLE cycle. Next tie -> m0.
- Locked burst: m1 holds `cyc` for 4 writes (0x1111..0x4444) while m0 requests -> m0 waits until m1 drops `cyc`, and readback shows all 4 values intact.
- Reset asserted mid-burst (OWN0, stb high) -> next cycle state IDLE, `s_stb_o = 0`, no ack to m0. First tie after reset -> m0.
- `ARB_WATCHDOG_EN` with `TIMEOUT_CYCLES = 4` and a slave model that never acks -> `m1_err_o` is a 1-cycle pulse exactly 4 cycles after stb, with `s_stb_o` low that cycle. Without the macro, `err` stays 0 indefinitely.
- Stray ack: slave ack injected while IDLE -> neither master acked.
